// File: rtl/instr_fetch_rom.sv
// Synchronous-read instruction memory with own fetch PC and QD-entry prefetch queue; address-to-queue 2 edges, 1 instr/cycle.
// Decode backpressure stalls issue via a count+in-flight credit; redirect flushes. `INSTR_ROM_LOAD_EN adds a write port.
module instr_fetch_rom #(
   parameter int             A        = 8,
   parameter int             W        = 9,
   parameter int             QD       = 4,
   parameter logic [A-1:0]   RESET_PC = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          redirect_valid,
   input  logic [A-1:0]  redirect_addr,
`ifdef INSTR_ROM_LOAD_EN
   input  logic          load_we,
   input  logic [A-1:0]  load_addr,
   input  logic [W-1:0]  load_data,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_instr,
   output logic [A-1:0]  out_addr
);

   localparam int PW = $clog2(QD);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [A-1:0] addr;
      logic [W-1:0] instr;
   } entry_t;

   logic [W-1:0]  inst_rom [2**A];

   logic [A-1:0]  r_pc;
   logic [A-1:0]  r_rd_addr;
   logic [W-1:0]  r_rd_data;
   logic          r_rd_valid;

   entry_t        r_q [QD];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic [CW:0]   w_inflight;
   logic          w_credit;
   logic          w_issue;
   logic          w_push;
   logic          w_pop;
   entry_t        w_head;

   // Queued entries plus the read in flight must never exceed QD.
   assign w_inflight = {1'b0, r_count} + {{CW{1'b0}}, r_rd_valid};
   assign w_credit   = w_inflight < (CW+1)'(QD);
   assign w_issue    = !redirect_valid && w_credit;
   assign w_push     = !redirect_valid && r_rd_valid;
   assign w_pop      = !redirect_valid && out_valid && out_ready;

   assign w_head    = r_q[r_rd_ptr];
   assign out_valid = (r_count != '0);
   assign out_instr = out_valid ? w_head.instr : '0;
   assign out_addr  = out_valid ? w_head.addr  : '0;

   always_ff @(posedge clk) begin
      if (w_issue)
         r_rd_data <= inst_rom[r_pc];
`ifdef INSTR_ROM_LOAD_EN
      if (load_we)
         inst_rom[load_addr] <= load_data;
`endif
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_q[r_wr_ptr] <= '{addr: r_rd_addr, instr: r_rd_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_rd_addr  <= '0;
         r_rd_valid <= 1'b0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_addr;
         r_rd_valid <= 1'b0;
      end else if (w_issue) begin
         r_rd_addr  <= r_pc;
         r_rd_valid <= 1'b1;
         r_pc       <= r_pc + A'(1);
      end else begin
         r_rd_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (redirect_valid) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overrun: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && r_count == CW'(QD)));

endmodule
